// File: rtl/activation_repair_buffer.sv
// activation_repair_buffer
// Lane-wise flip/patch correction of an M-lane activation vector, buffered in a
// DEPTH-entry vector FIFO and drained through a valid/ready stream once
// start_reading is seen. Flip and patch statistics saturate at their maximum.
// All outputs are registered; nothing on the input side reaches an output
// combinationally.

module activation_repair_buffer #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*M-1:0]               activation_org,
  input  logic [N*M-1:0]               activation_cache,
  input  logic [M-1:0]                 f,
  input  logic [M-1:0]                 p,
  input  logic                         start_reading,
  input  logic                         clear_counts,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*M-1:0]               activation_final,
  output logic [N*M-1:0]               flipped_out,
  output logic [N*M-1:0]               patched_out,
  output logic [CNT_W-1:0]             flip_count,
  output logic [CNT_W-1:0]             patch_count,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

  localparam int VW    = N * M;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BC_W  = $clog2(DEPTH + 1);
  localparam int PC_W  = $clog2(M + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Number of set bits in a lane mask.
  function automatic logic [PC_W-1:0] popcount(input logic [M-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < M; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  state_t            state_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [BC_W-1:0]   count_r;

  logic [VW-1:0]     mem_final_r   [DEPTH];
  logic [VW-1:0]     mem_flipped_r [DEPTH];
  logic [VW-1:0]     mem_patched_r [DEPTH];

  logic [VW-1:0]     final_s;
  logic [VW-1:0]     flipped_s;
  logic [VW-1:0]     patched_s;

  logic              push_s;
  logic              pop_s;
  logic [PTR_W-1:0]  rd_next_s;
  logic [PTR_W-1:0]  wr_next_s;
  logic [BC_W-1:0]   count_next_s;

  logic              head_load_s;
  logic [VW-1:0]     head_final_s;
  logic [VW-1:0]     head_flipped_s;
  logic [VW-1:0]     head_patched_s;

  // Per-lane correction; patch takes priority over flip in the final view.
  always_comb begin
    final_s   = '0;
    flipped_s = '0;
    patched_s = '0;
    for (int i = 0; i < M; i++) begin
      if (f[i]) begin
        flipped_s[i*N +: N] = ~activation_org[i*N +: N];
      end else begin
        flipped_s[i*N +: N] = activation_org[i*N +: N];
      end
      if (p[i]) begin
        patched_s[i*N +: N] = activation_cache[i*N +: N];
        final_s[i*N +: N]   = activation_cache[i*N +: N];
      end else begin
        patched_s[i*N +: N] = activation_org[i*N +: N];
        final_s[i*N +: N]   = flipped_s[i*N +: N];
      end
    end
  end

  // Handshake decode and next pointer/occupancy values. in_ready and out_valid
  // are mutually exclusive, so push and pop never occur in the same cycle.
  always_comb begin
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    rd_next_s = rd_ptr_r;
    wr_next_s = wr_ptr_r;
    if (pop_s) begin
      rd_next_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_next_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_next_s = wr_ptr_r;
    end
    if (push_s) begin
      count_next_s = count_r + BC_W'(1);
    end else if (pop_s) begin
      count_next_s = count_r - BC_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Head view for the next cycle. A write into an empty FIFO lands at the read
  // pointer, so it is forwarded directly; with nothing left the last popped
  // entry is held.
  always_comb begin
    head_load_s    = 1'b0;
    head_final_s   = mem_final_r[rd_next_s];
    head_flipped_s = mem_flipped_r[rd_next_s];
    head_patched_s = mem_patched_r[rd_next_s];
    if (count_next_s != BC_W'(0)) begin
      head_load_s = 1'b1;
      if (push_s && (count_r == BC_W'(0))) begin
        head_final_s   = final_s;
        head_flipped_s = flipped_s;
        head_patched_s = patched_s;
      end else begin
        head_final_s   = mem_final_r[rd_next_s];
        head_flipped_s = mem_flipped_r[rd_next_s];
        head_patched_s = mem_patched_r[rd_next_s];
      end
    end else begin
      head_load_s = 1'b0;
    end
  end

  // Vector storage; contents are not reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_final_r[wr_ptr_r]   <= final_s;
      mem_flipped_r[wr_ptr_r] <= flipped_s;
      mem_patched_r[wr_ptr_r] <= patched_s;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
    end
  end

  // Registered head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      activation_final <= '0;
      flipped_out      <= '0;
      patched_out      <= '0;
    end else if (head_load_s) begin
      activation_final <= head_final_s;
      flipped_out      <= head_flipped_s;
      patched_out      <= head_patched_s;
    end
  end

  // Saturating statistics; clear beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      flip_count  <= '0;
      patch_count <= '0;
    end else if (push_s) begin
      flip_count  <= sat_add(flip_count, popcount(f & ~p));
      patch_count <= sat_add(patch_count, popcount(p));
    end
  end

  // Fill/drain control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_reading && ((count_r != BC_W'(0)) || push_s)) begin
            state_r   <= READ;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state_r   <= IDLE;
            in_ready  <= (count_next_s < BC_W'(DEPTH));
            out_valid <= 1'b0;
          end
        end
        READ: begin
          if (pop_s && (count_r == BC_W'(1))) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            state_r   <= READ;
            in_ready  <= 1'b0;
            out_valid <= (count_next_s != BC_W'(0));
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign buf_count = count_r;

endmodule

// File: doc/activation_repair_buffer.md
Name: activation_repair_buffer

Overview:
- Parametrised successor of the activation test/mitigation datapath.
- Per write, applies lane-wise bit-flip and cache-patch correction to an M-lane activation vector, then stores the result in a DEPTH-entry vector FIFO.
- Drains the FIFO through a valid/ready stream after start_reading.
- Keeps saturating flip and patch statistics.
- Sits between the activation source/cache and the downstream PE array.

Parameters:
- N, 16, activation width in bits
- M, 16, lanes per vector
- DEPTH, 4, buffered vectors (≥2)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  write request
- in_ready  out  1  write accepted when in_valid&&in_ready
- activation_org  in  N×M  original activations
- activation_cache  in  N×M  cached (known-good) activations
- f  in  1×M  per-lane flip enable
- p  in  1×M  per-lane patch enable
- start_reading  in  1  pulse: begin draining buffer
- clear_counts  in  1  zero statistics counters
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head
- activation_final  out  N×M  corrected vector (head)
- flipped_out  out  N×M  flip-only view (head)
- patched_out  out  N×M  patch-only view (head)
- flip_count  out  CNT_W  lanes flipped (f&&!p) since clear
- patch_count  out  CNT_W  lanes patched (p) since clear
- buf_count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Lane functions, evaluated on write (i = lane):
  - flipped[i] = f[i] ? ~org[i] : org[i]
  - patched[i] = p[i] ? cache[i] : org[i]
  - final[i] = p[i] ? cache[i] : flipped[i] (patch has priority over flip)
- Each FIFO entry stores all three vectors. Outputs are driven only from storage at the read pointer; there is no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE → READ on start_reading when buf_count>0 or when a write is accepted in the same cycle.
  - start_reading while empty with no write: ignored, stays IDLE.
  - READ → IDLE on the cycle the last entry pops (buf_count 1→0). start_reading in READ is ignored.
- Handshakes:
  - in_ready = (state==IDLE) && (buf_count<DEPTH). Writes while in_ready=0 are dropped: no storage, no count.
  - out_valid = (state==READ) && (buf_count>0). Pop on out_valid&&out_ready.
  - While out_ready=0, head outputs hold stable.
- Latency: the first out_valid appears the cycle after start_reading is sampled. Entries leave in write order, one per cycle at full throughput.
- Pointers wrap modulo DEPTH. buf_count never exceeds DEPTH or goes below 0.
- Counters:
  - Accepted write adds popcount(f&~p) to flip_count and popcount(p) to patch_count.
  - Counters saturate at 2^CNT_W−1.
  - clear_counts wins over a same-cycle write: the counter becomes 0 and that write's contribution is lost.
- Reset, including mid-READ: state IDLE, pointers 0, buf_count 0, counters 0, out_valid 0, all data outputs 0, in_ready 1 from the following cycle. Buffered contents are discarded.
- When empty, data outputs show the last-popped entry (or 0 after reset). Consumers must qualify them with out_valid.

Test Plan:
- Lane modes, one write:
  - lane0 org=0x00FF, f=1, p=0 → final=flipped=0xFF00, patched=0x00FF
  - lane1 org=0x0001, cache=0x1234, p=1 → final=patched=0x1234, flipped=0x0001
  - lane2 f=p=1, org=0x000F, cache=0xBEEF → final=0xBEEF, flipped=0xFFF0
  - After start_reading, out_valid=1 next cycle; flip_count=1, patch_count=2.
- Full/wrap (DEPTH=4):
  - 5 consecutive writes tagged lane0 org=1..5 → in_ready=0 after 4th; 5th dropped; buf_count=4.
  - start_reading with out_ready=1 → outputs 1,2,3,4 on consecutive cycles, then IDLE.
  - Repeat → order preserved across pointer wrap.
- Backpressure: READ with out_ready=0 for 3 cycles → head outputs and buf_count constant; out_ready=1 → single pop per cycle.
- Empty start and same-cycle write:
  - start_reading with buf_count=0 → stays IDLE, out_valid=0.
  - start_reading together with an accepted write → READ; that entry appears next cycle.
- Counters (CNT_W=4, M=16):
  - Two writes with all f=1, p=0 → flip_count=15 (saturated).
  - clear_counts with a simultaneous write → both counters 0.
- Reset mid-READ with 3 entries → next cycle out_valid=0, buf_count=0, outputs 0, counters 0; a new write/read cycle works normally.
